// File: rtl/exec_pkg.sv
// Shared definitions for exec_unit: opcodes, FSM states, instruction field positions.
// The FILL state only exists when EXEC_UNIT_FILL_EN is defined.
package exec_pkg;

    localparam logic [3:0] OpNop   = 4'd0;
    localparam logic [3:0] OpPlot  = 4'd1;
    localparam logic [3:0] OpLoad  = 4'd2;
    localparam logic [3:0] OpStore = 4'd3;
    localparam logic [3:0] OpFill  = 4'd4;

    localparam int unsigned OpLsb   = 28;
    localparam int unsigned XLsb    = 0;
    localparam int unsigned YLsb    = 8;
    localparam int unsigned ColLsb  = 15;
    localparam int unsigned PlotBit = 18;
    localparam int unsigned WLsb    = 18;
    localparam int unsigned HLsb    = 23;
    localparam int unsigned DataLsb = 16;
    localparam int unsigned StAddrW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StPlot,
        StLoad,
        StStore
`ifdef EXEC_UNIT_FILL_EN
        , StFill
`endif
    } state_e;

    function automatic logic [3:0] get_op(input logic [31:0] i_instr);
        return i_instr[OpLsb +: 4];
    endfunction

endpackage

// File: rtl/exec_fifo.sv
// First-word-fall-through instruction queue; DEPTH must be a power of two.
module exec_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Queued instruction executor driving a pixel plotter and a simple memory port.
// Define EXEC_UNIT_FILL_EN to build in the rectangle FILL opcode.
module exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned MEM_RD_LAT = 2,
    parameter int unsigned QDEPTH     = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic [7:0]        x,
    output logic [6:0]        y,
    output logic [2:0]        colour,
    output logic              plot,
    input  logic [DATA_W-1:0] mem_output,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write,
    output logic              illegal,
    output logic              finished
);

    localparam int unsigned CntW = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    logic [31:0]       w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_unused_head;
    state_e            r_state;
    logic [7:0]        r_x;
    logic [6:0]        r_y;
    logic [2:0]        r_colour;
    logic              r_plot;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_result;
    logic              r_result_valid;
    logic              r_illegal;
    logic [CntW-1:0]   r_lat_cnt;
`ifdef EXEC_UNIT_FILL_EN
    logic [7:0]        r_x_org;
    logic [6:0]        r_y_org;
    logic [4:0]        r_w_last;
    logic [4:0]        r_h_last;
    logic [4:0]        r_col;
    logic [4:0]        r_row;
`endif

    exec_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .i_push  (instr_valid),
        .i_wdata (instr),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop         = (r_state == StIdle) && !w_empty;
    assign w_unused_head = ^w_head;
    assign instr_ready   = !w_full;
    assign finished      = (r_state == StIdle) && w_empty;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state        <= StIdle;
            r_x            <= '0;
            r_y            <= '0;
            r_colour       <= '0;
            r_plot         <= 1'b0;
            r_addr         <= '0;
            r_data         <= '0;
            r_mem_write    <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_illegal      <= 1'b0;
            r_lat_cnt      <= '0;
`ifdef EXEC_UNIT_FILL_EN
            r_x_org        <= '0;
            r_y_org        <= '0;
            r_w_last       <= '0;
            r_h_last       <= '0;
            r_col          <= '0;
            r_row          <= '0;
`endif
        end else begin
            r_plot         <= 1'b0;
            r_mem_write    <= 1'b0;
            r_result_valid <= 1'b0;
            r_illegal      <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        case (get_op(w_head))
                            OpNop: ;
                            OpPlot: begin
                                r_x      <= w_head[XLsb +: 8];
                                r_y      <= w_head[YLsb +: 7];
                                r_colour <= w_head[ColLsb +: 3];
                                r_plot   <= w_head[PlotBit];
                                r_state  <= StPlot;
                            end
                            OpLoad: begin
                                r_addr    <= w_head[ADDR_W-1:0];
                                r_lat_cnt <= '0;
                                r_state   <= StLoad;
                            end
                            OpStore: begin
                                r_addr      <= ADDR_W'(w_head[StAddrW-1:0]);
                                r_data      <= w_head[DataLsb +: DATA_W];
                                r_mem_write <= 1'b1;
                                r_state     <= StStore;
                            end
`ifdef EXEC_UNIT_FILL_EN
                            OpFill: begin
                                r_x      <= w_head[XLsb +: 8];
                                r_y      <= w_head[YLsb +: 7];
                                r_colour <= w_head[ColLsb +: 3];
                                r_plot   <= 1'b1;
                                r_x_org  <= w_head[XLsb +: 8];
                                r_y_org  <= w_head[YLsb +: 7];
                                r_w_last <= w_head[WLsb +: 5];
                                r_h_last <= w_head[HLsb +: 5];
                                r_col    <= '0;
                                r_row    <= '0;
                                r_state  <= StFill;
                            end
`endif
                            default: r_illegal <= 1'b1;
                        endcase
                    end
                end
                StPlot, StStore: r_state <= StIdle;
                StLoad: begin
                    // Capture lands MEM_RD_LAT edges after the address was registered.
                    if (r_lat_cnt == CntW'(MEM_RD_LAT - 1)) begin
                        r_result       <= mem_output;
                        r_result_valid <= 1'b1;
                        r_state        <= StIdle;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + CntW'(1);
                    end
                end
`ifdef EXEC_UNIT_FILL_EN
                StFill: begin
                    if (r_col != r_w_last) begin
                        r_col  <= r_col + 5'd1;
                        r_x    <= r_x_org + {3'b000, r_col} + 8'd1;
                        r_plot <= 1'b1;
                    end else if (r_row != r_h_last) begin
                        r_col  <= '0;
                        r_row  <= r_row + 5'd1;
                        r_x    <= r_x_org;
                        r_y    <= r_y_org + {2'b00, r_row} + 7'd1;
                        r_plot <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                    end
                end
`endif
                default: r_state <= StIdle;
            endcase
        end
    end

    assign x            = r_x;
    assign y            = r_y;
    assign colour       = r_colour;
    assign plot         = r_plot;
    assign mem_address  = r_addr;
    assign mem_data     = r_data;
    assign mem_write    = r_mem_write;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign illegal      = r_illegal;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit; FILL checks depend on EXEC_UNIT_FILL_EN.
module tb_exec_unit;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned MEM_RD_LAT = 2;
    localparam int unsigned QDEPTH     = 4;

    logic              clock;
    logic              resetn;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [2:0]        colour;
    logic              plot;
    logic [DATA_W-1:0] mem_output;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_write;
    logic              illegal;
    logic              finished;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int rv_cnt = 0;
    int ill_cnt = 0;
    logic [17:0] plot_q[$];
    logic [DATA_W-1:0] mem [256];

    exec_unit #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_RD_LAT (MEM_RD_LAT),
        .QDEPTH     (QDEPTH)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .result       (result),
        .result_valid (result_valid),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .mem_output   (mem_output),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_write    (mem_write),
        .illegal      (illegal),
        .finished     (finished)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: read data registered once, so the DUT capture edge sees it in time.
    always @(posedge clock) begin
        if (mem_write) mem[mem_address[7:0]] <= mem_data;
        mem_output <= mem[mem_address[7:0]];
    end

    always @(negedge clock) begin
        if (resetn) begin
            if (plot) plot_q.push_back({x, y, colour});
            if (mem_write) wr_cnt <= wr_cnt + 1;
            if (result_valid) rv_cnt <= rv_cnt + 1;
            if (illegal) ill_cnt <= ill_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the push edge.
    task automatic send(input logic [31:0] v, input string tag);
        bit acc = 1'b0;
        instr       = v;
        instr_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = instr_ready;
            @(negedge clock);
        end
        if (!acc) chk({tag, "_accept"}, {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && !finished; i++) @(negedge clock);
        chk(tag, {31'd0, finished}, 32'd1);
        @(negedge clock);
    endtask

    int pb;
    int wb;
    int rb;
    int ib;
    logic [17:0] e;

    initial begin
        resetn      = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        repeat (3) @(negedge clock);
        chk("rst_finished", {31'd0, finished}, 32'd1);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_result", {20'd0, result}, 32'd0);
        chk("rst_plot", {31'd0, plot}, 32'd0);
        chk("rst_x", {24'd0, x}, 32'd0);
        chk("rst_addr", {16'd0, mem_address}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        // PLOT: x=3, y=10, colour bits [17:15] = 3'b010
        pb = plot_q.size();
        send(32'h1005_0A03, "plot");
        instr_valid = 1'b0;
        wait_idle("plot_finished");
        chk("plot_count", plot_q.size() - pb, 32'd1);
        e = plot_q[pb];
        chk("plot_x", {24'd0, e[17:10]}, 32'd3);
        chk("plot_y", {25'd0, e[9:3]}, 32'd10);
        chk("plot_colour", {29'd0, e[2:0]}, 32'd2);

        // STORE 0xABC to 0x0040
        wb = wr_cnt;
        send(32'h3ABC_0040, "store");
        instr_valid = 1'b0;
        wait_idle("store_finished");
        chk("store_wr_count", wr_cnt - wb, 32'd1);
        chk("store_addr", {16'd0, mem_address}, 32'h40);
        chk("store_data", {20'd0, mem_data}, 32'hABC);
        chk("store_wr_low", {31'd0, mem_write}, 32'd0);

        // LOAD 0x0040: address after pop edge, result_valid two edges later
        rb = rv_cnt;
        send(32'h2000_0040, "load");
        instr_valid = 1'b0;
        chk("load_rv_c0", {31'd0, result_valid}, 32'd0);
        @(negedge clock);
        chk("load_addr", {16'd0, mem_address}, 32'h40);
        chk("load_wr_low", {31'd0, mem_write}, 32'd0);
        chk("load_rv_c1", {31'd0, result_valid}, 32'd0);
        @(negedge clock);
        chk("load_rv_c2", {31'd0, result_valid}, 32'd0);
        @(negedge clock);
        chk("load_rv_c3", {31'd0, result_valid}, 32'd1);
        chk("load_result", {20'd0, result}, 32'hABC);
        @(negedge clock);
        chk("load_rv_c4", {31'd0, result_valid}, 32'd0);
        wait_idle("load_finished");
        chk("load_rv_count", rv_cnt - rb, 32'd1);

        // Queue overflow: two LOADs stall the FSM while five PLOTs arrive
        pb = plot_q.size();
        send(32'h2000_0040, "ovf_ld1");
        send(32'h2000_0040, "ovf_ld2");
        for (int i = 1; i <= 4; i++) send(32'h1004_0000 | 32'(i), "ovf_plot");
        chk("ovf_ready_low", {31'd0, instr_ready}, 32'd0);
        send(32'h1004_0005, "ovf_plot5");
        instr_valid = 1'b0;
        wait_idle("ovf_finished");
        chk("ovf_count", plot_q.size() - pb, 32'd5);
        for (int i = 0; i < 5; i++) begin
            e = plot_q[pb + i];
            chk($sformatf("ovf_order%0d", i), {24'd0, e[17:10]}, 32'(i + 1));
        end

        // FILL (10,5), width field 2, height field 1
        pb = plot_q.size();
        ib = ill_cnt;
        send(32'h4088_050A, "fill");
        instr_valid = 1'b0;
        wait_idle("fill_finished");
`ifdef EXEC_UNIT_FILL_EN
        chk("fill_count", plot_q.size() - pb, 32'd6);
        for (int i = 0; i < 6; i++) begin
            e = plot_q[pb + i];
            chk($sformatf("fill_x%0d", i), {24'd0, e[17:10]}, 32'(10 + (i % 3)));
            chk($sformatf("fill_y%0d", i), {25'd0, e[9:3]}, 32'(5 + (i / 3)));
        end
`else
        chk("fill_off_illegal", ill_cnt - ib, 32'd1);
        chk("fill_off_plots", plot_q.size() - pb, 32'd0);
`endif

        // Unknown opcode 0xF
        pb = plot_q.size();
        ib = ill_cnt;
        wb = wr_cnt;
        send(32'hF000_0000, "illegal");
        instr_valid = 1'b0;
        wait_idle("ill_finished");
        chk("ill_count", ill_cnt - ib, 32'd1);
        chk("ill_plots", plot_q.size() - pb, 32'd0);
        chk("ill_writes", wr_cnt - wb, 32'd0);

        // NOP: no activity at all
        rb = rv_cnt;
        send(32'h0000_0000, "nop");
        instr_valid = 1'b0;
        wait_idle("nop_finished");
        chk("nop_plots", plot_q.size() - pb, 32'd0);
        chk("nop_illegal", ill_cnt - ib - 1, 32'd0);
        chk("nop_rv", rv_cnt - rb, 32'd0);

        // Reset while a LOAD is waiting for memory
        rb = rv_cnt;
        send(32'h2000_0040, "rst_load");
        instr_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        chk("rstld_rv", {31'd0, result_valid}, 32'd0);
        chk("rstld_result", {20'd0, result}, 32'd0);
        chk("rstld_finished", {31'd0, finished}, 32'd1);
        chk("rstld_ready", {31'd0, instr_ready}, 32'd1);
        repeat (4) @(negedge clock);
        chk("rstld_rv_count", rv_cnt - rb, 32'd0);
        chk("rstld_result_hold", {20'd0, result}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
